sobel_gradient: RTL and testbench
=================================

Name: sobel_gradient

Overview:
- Upstream neighbour of the magnitude stage in the edge-detection datapath.
- Accepts one 3-pixel vertical column per handshake from the line-buffer stage (top/mid/bottom rows), in raster order.
- Keeps a 3x3 sliding window and computes the signed Sobel gradients gx and gy.
- Delivers gx/gy with valid/ready and line/frame markers; gx/gy feed magnitude's a/b inputs directly.

Parameters:
IMG_WIDTH, 64, columns per input line (>=3)
IMG_HEIGHT, 64, image rows; window-centre lines per frame = IMG_HEIGHT-2 (>=3)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  column data valid
in_ready  output  1  block can accept a column this cycle
in_top  input  8  unsigned pixel, row y-1
in_mid  input  8  unsigned pixel, row y
in_bot  input  8  unsigned pixel, row y+1
in_sof  input  1  column is column 0 of line 0 of a frame
out_valid  output  1  gx/gy valid
out_ready  input  1  downstream accepts result
gx  output  11  signed horizontal gradient
gy  output  11  signed vertical gradient
out_eol  output  1  result is the last of its line
out_eof  output  1  result is the last of the frame

Behaviour:
- Reset (async, rst_n low): out_valid=0, gx=0, gy=0, out_eol=0, out_eof=0. Window registers, col_cnt and row_cnt = 0. in_ready=1 while out_valid=0.
- Handshakes:
  - Input accept: in_valid && in_ready at a rising edge.
  - Output accept: out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register; no combinational path from in_valid to in_ready).
  - Output holds gx/gy/out_eol/out_eof stable while out_valid && !out_ready.
- Window: on each input accept, left<=centre, centre<=right, right<=new column. Each column is {top,mid,bot}.
- col_cnt: 0..IMG_WIDTH-1, increments per accept and wraps to 0 after IMG_WIDTH-1.
- row_cnt: 0..IMG_HEIGHT-3, increments on col_cnt wrap and wraps to 0 after IMG_HEIGHT-3.
- in_sof on an accepted column forces that column to be col 0, row 0. Counters then advance from there. Mid-frame in_sof aborts the partial line with no output for it.
- Result generation: an accepted column with col_cnt>=2 (post-sof value) completes a window. At the same edge the output register loads:
  - gx = (r_t + 2*r_m + r_b) - (l_t + 2*l_m + l_b)
  - gy = (l_t + 2*c_t + r_t) - (l_b + 2*c_b + r_b)
  - Here l/c/r are the window columns including the new column as r.
- Latency: result valid the cycle after the completing column is accepted (1 edge).
- Accepted columns with col_cnt 0 or 1 produce no result; the window does not span line boundaries.
- Output count: IMG_WIDTH-2 results per line, (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
- Width: sums are 10-bit unsigned (max 1020). Differences are computed in 11-bit signed, range -1020..+1020, with no saturation or overflow.
- out_eol = 1 with the result whose completing column has col_cnt=IMG_WIDTH-1.
- out_eof = out_eol && row_cnt=IMG_HEIGHT-3.
- out_valid update per edge:
  - set when a result loads;
  - cleared on output accept with no new load;
  - stays 1 when an output accept and a new load occur in the same edge (back-to-back, full throughput).
- Stall: while out_valid && !out_ready, in_ready=0. Window and counters freeze and input is ignored.
- Reset mid-frame: all state cleared immediately; the next frame must start with in_sof or col 0.

Test Plan:
- Flat image, all pixels 100, IMG_WIDTH=8, IMG_HEIGHT=4, out_ready=1 -> 12 results, all gx=0, gy=0; out_eol on results 6 and 12; out_eof on result 12 only.
- Vertical step, left column 0, centre and right 255 (all rows) -> gx=+1020, gy=0. Mirrored (left 255, centre and right 0) -> gx=-1020 (11'h404).
- Horizontal step, top row 255, mid and bottom 0, all columns -> gx=0, gy=+1020. Reverse -> gy=-1020.
- Backpressure: out_ready low 5 cycles while in_valid held high -> in_ready=0 for those cycles; gx/gy unchanged; no column lost; results in order; one result per cycle once out_ready=1.
- Line boundary: stream two lines with distinct values per line -> first two columns of line 2 produce no output; no result mixes columns from two lines.
- rst_n pulsed low mid-line for one cycle, asynchronously between edges -> out_valid drops immediately; the next fresh line produces its first result only on its third column.

Source files
------------

// File: rtl/sobel_gradient.sv
// 3x3 Sobel gradient stage: slides a window over incoming pixel columns and
// emits signed gx/gy with line/frame markers through a single output register.
module sobel_gradient #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_top,
   input  logic [7:0]  in_mid,
   input  logic [7:0]  in_bot,
   input  logic        in_sof,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [10:0] gx,
   output logic [10:0] gy,
   output logic        out_eol,
   output logic        out_eof
);

   localparam int LINES = IMG_HEIGHT - 2;
   localparam int CW    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
   localparam int RW    = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [CW-1:0] ColLast     = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] ColFirstOut = CW'(2);
   localparam logic [RW-1:0] RowLast     = RW'(LINES - 1);

   logic [23:0]   leftCol_q, centreCol_q, rightCol_q;
   logic [23:0]   leftCol_d, centreCol_d, rightCol_d;
   logic [CW-1:0] colCnt_q, colCnt_d;
   logic [RW-1:0] rowCnt_q, rowCnt_d;
   logic          outValid_q, outValid_d;
   logic [10:0]   gx_q, gx_d, gy_q, gy_d;
   logic          eol_q, eol_d, eof_q, eof_d;

   logic          accept, load, colLastHit, rowLastHit;
   logic [CW-1:0] colEff;
   logic [RW-1:0] rowEff;
   logic [23:0]   newCol;
   logic [9:0]    leftSum, rightSum, topSum, botSum;

   assign in_ready  = !outValid_q || out_ready;
   assign out_valid = outValid_q;
   assign gx        = gx_q;
   assign gy        = gy_q;
   assign out_eol   = eol_q;
   assign out_eof   = eof_q;

   // Column layout is {top, mid, bot}; the new column becomes the window's right edge.
   always_comb begin
      accept     = in_valid && in_ready;
      colEff     = in_sof ? '0 : colCnt_q;
      rowEff     = in_sof ? '0 : rowCnt_q;
      colLastHit = (colEff == ColLast);
      rowLastHit = (rowEff == RowLast);
      load       = accept && (colEff >= ColFirstOut);
      newCol     = {in_top, in_mid, in_bot};

      leftSum  = {2'b00, centreCol_q[23:16]} + {1'b0, centreCol_q[15:8], 1'b0}
               + {2'b00, centreCol_q[7:0]};
      rightSum = {2'b00, newCol[23:16]} + {1'b0, newCol[15:8], 1'b0}
               + {2'b00, newCol[7:0]};
      topSum   = {2'b00, centreCol_q[23:16]} + {1'b0, rightCol_q[23:16], 1'b0}
               + {2'b00, newCol[23:16]};
      botSum   = {2'b00, centreCol_q[7:0]} + {1'b0, rightCol_q[7:0], 1'b0}
               + {2'b00, newCol[7:0]};

      leftCol_d   = leftCol_q;
      centreCol_d = centreCol_q;
      rightCol_d  = rightCol_q;
      colCnt_d    = colCnt_q;
      rowCnt_d    = rowCnt_q;
      if (accept) begin
         leftCol_d   = centreCol_q;
         centreCol_d = rightCol_q;
         rightCol_d  = newCol;
         if (colLastHit) begin
            colCnt_d = '0;
            rowCnt_d = rowLastHit ? '0 : rowEff + 1'b1;
         end else begin
            colCnt_d = colEff + 1'b1;
            rowCnt_d = rowEff;
         end
      end

      gx_d  = gx_q;
      gy_d  = gy_q;
      eol_d = eol_q;
      eof_d = eof_q;
      if (load) begin
         gx_d  = {1'b0, rightSum} - {1'b0, leftSum};
         gy_d  = {1'b0, topSum} - {1'b0, botSum};
         eol_d = colLastHit;
         eof_d = colLastHit && rowLastHit;
      end

      if (load)
         outValid_d = 1'b1;
      else if (out_ready)
         outValid_d = 1'b0;
      else
         outValid_d = outValid_q;
   end

   // All window, counter and output state clears asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leftCol_q   <= '0;
         centreCol_q <= '0;
         rightCol_q  <= '0;
         colCnt_q    <= '0;
         rowCnt_q    <= '0;
         outValid_q  <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         leftCol_q   <= leftCol_d;
         centreCol_q <= centreCol_d;
         rightCol_q  <= rightCol_d;
         colCnt_q    <= colCnt_d;
         rowCnt_q    <= rowCnt_d;
         outValid_q  <= outValid_d;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
      end
   end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench for sobel_gradient on an 8x4 image with hand-computed gradients.
module tb_sobel_gradient;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_top, in_mid, in_bot;
   logic        in_sof;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] gx, gy;
   logic        out_eol, out_eof;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [10:0] qGx[$];
   logic [10:0] qGy[$];
   logic        qEol[$];
   logic        qEof[$];
   int          qCyc[$];

   sobel_gradient #(.IMG_WIDTH(8), .IMG_HEIGHT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_top(in_top), .in_mid(in_mid), .in_bot(in_bot), .in_sof(in_sof),
      .out_valid(out_valid), .out_ready(out_ready), .gx(gx), .gy(gy),
      .out_eol(out_eol), .out_eof(out_eof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records every result that will be taken at the coming rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         qGx.push_back(gx);
         qGy.push_back(gy);
         qEol.push_back(out_eol);
         qEof.push_back(out_eof);
         qCyc.push_back(cyc);
      end
   end

   task automatic clearQ();
      qGx.delete(); qGy.delete(); qEol.delete(); qEof.delete(); qCyc.delete();
   endtask

   // Presents one column and returns just after the edge that accepted it; in_valid stays high.
   task automatic sendCol(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                          input logic s);
      int waited = 0;
      in_valid = 1'b1; in_top = t; in_mid = m; in_bot = b; in_sof = s;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 100) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout in_ready stuck at %0b, required 1", in_ready);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; in_sof = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      in_top = '0; in_mid = '0; in_bot = '0;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (gx !== 11'd0) begin errors++; $display("[TB] FAIL reset_gx got %h want 000", gx); end
      checks++; if (gy !== 11'd0) begin errors++; $display("[TB] FAIL reset_gy got %h want 000", gy); end
      checks++; if (out_eol !== 1'b0 || out_eof !== 1'b0) begin errors++; $display("[TB] FAIL reset_markers got eol=%0b eof=%0b want 0/0", out_eol, out_eof); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_flat();
      clearQ();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 8; c++)
            sendCol(8'd100, 8'd100, 8'd100, (r == 0 && c == 0));
      idle(3);
      checks++;
      if (qGx.size() != 12) begin errors++; $display("[TB] FAIL flat_count got %0d want 12", qGx.size()); end
      else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (qGx[i] !== 11'd0 || qGy[i] !== 11'd0) begin errors++; $display("[TB] FAIL flat_grad[%0d] got gx=%h gy=%h want 000/000", i, qGx[i], qGy[i]); end
            checks++;
            if (qEol[i] !== (i == 5 || i == 11) || qEof[i] !== (i == 11)) begin
               errors++; $display("[TB] FAIL flat_markers[%0d] got eol=%0b eof=%0b want %0b/%0b", i, qEol[i], qEof[i], (i == 5 || i == 11), (i == 11));
            end
         end
      end
   endtask

   task automatic test_vertical_step();
      clearQ();
      sendCol(8'd0, 8'd0, 8'd0, 1'b1);
      for (int c = 1; c < 8; c++) sendCol(8'd255, 8'd255, 8'd255, 1'b0);
      idle(3);
      checks++;
      if (qGx.size() != 6) begin errors++; $display("[TB] FAIL vstep_count got %0d want 6", qGx.size()); end
      else begin
         checks++; if (qGx[0] !== 11'd1020 || qGy[0] !== 11'd0) begin errors++; $display("[TB] FAIL vstep_rise got gx=%h gy=%h want 3fc/000", qGx[0], qGy[0]); end
         checks++; if (qGx[1] !== 11'd0) begin errors++; $display("[TB] FAIL vstep_flat got gx=%h want 000", qGx[1]); end
      end
      clearQ();
      sendCol(8'd255, 8'd255, 8'd255, 1'b1);
      for (int c = 1; c < 8; c++) sendCol(8'd0, 8'd0, 8'd0, 1'b0);
      idle(3);
      checks++;
      if (qGx.size() != 6) begin errors++; $display("[TB] FAIL vstep_mirror_count got %0d want 6", qGx.size()); end
      else begin
         checks++; if (qGx[0] !== 11'h404 || qGy[0] !== 11'd0) begin errors++; $display("[TB] FAIL vstep_fall got gx=%h gy=%h want 404/000", qGx[0], qGy[0]); end
      end
   endtask

   task automatic test_horizontal_step();
      clearQ();
      for (int c = 0; c < 8; c++) sendCol(8'd255, 8'd0, 8'd0, (c == 0));
      idle(3);
      checks++;
      if (qGy.size() != 6) begin errors++; $display("[TB] FAIL hstep_count got %0d want 6", qGy.size()); end
      else begin
         checks++; if (qGy[0] !== 11'd1020 || qGx[0] !== 11'd0) begin errors++; $display("[TB] FAIL hstep_top got gx=%h gy=%h want 000/3fc", qGx[0], qGy[0]); end
         checks++; if (qGy[5] !== 11'd1020) begin errors++; $display("[TB] FAIL hstep_top_last got gy=%h want 3fc", qGy[5]); end
      end
      clearQ();
      for (int c = 0; c < 8; c++) sendCol(8'd0, 8'd0, 8'd255, (c == 0));
      idle(3);
      checks++;
      if (qGy.size() != 6) begin errors++; $display("[TB] FAIL hstep_rev_count got %0d want 6", qGy.size()); end
      else begin
         checks++; if (qGy[0] !== 11'h404 || qGx[0] !== 11'd0) begin errors++; $display("[TB] FAIL hstep_bot got gx=%h gy=%h want 000/404", qGx[0], qGy[0]); end
      end
   endtask

   // Top row ramps by 10 per column, so gx=20 and gy=40*(completing column-1).
   task automatic test_back_to_back();
      clearQ();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) sendCol(8'(10 * c), 8'd0, 8'd0, (c == 0));
      in_top = 8'd30; in_sof = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || gx !== 11'd20 || gy !== 11'd40) begin
            errors++; $display("[TB] FAIL stall_hold got rdy=%0b vld=%0b gx=%h gy=%h want 0/1/014/028", in_ready, out_valid, gx, gy);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 3; c < 8; c++) sendCol(8'(10 * c), 8'd0, 8'd0, 1'b0);
      idle(3);
      checks++;
      if (qGx.size() != 6) begin errors++; $display("[TB] FAIL stall_count got %0d want 6", qGx.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (qGx[i] !== 11'd20 || qGy[i] !== 11'(40 * (i + 1))) begin
               errors++; $display("[TB] FAIL stall_order[%0d] got gx=%h gy=%h want 014/%h", i, qGx[i], qGy[i], 11'(40 * (i + 1)));
            end
            if (i > 0) begin
               checks++;
               if (qCyc[i] != qCyc[i-1] + 1) begin errors++; $display("[TB] FAIL throughput[%0d] gap got %0d want 1", i, qCyc[i] - qCyc[i-1]); end
            end
         end
      end
   endtask

   task automatic test_line_boundary();
      clearQ();
      for (int c = 0; c < 8; c++) sendCol(8'(10 * c), 8'(10 * c), 8'(10 * c), (c == 0));
      for (int c = 0; c < 8; c++) sendCol(8'd200, 8'd200, 8'd200, 1'b0);
      idle(3);
      checks++;
      if (qGx.size() != 12) begin errors++; $display("[TB] FAIL line_count got %0d want 12", qGx.size()); end
      else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (qGx[i] !== ((i < 6) ? 11'd80 : 11'd0) || qGy[i] !== 11'd0) begin
               errors++; $display("[TB] FAIL line_mix[%0d] got gx=%h gy=%h want %h/000", i, qGx[i], qGy[i], (i < 6) ? 11'd80 : 11'd0);
            end
         end
         checks++; if (qEof[11] !== 1'b1 || qEol[6] !== 1'b0) begin errors++; $display("[TB] FAIL line_markers got eof11=%0b eol6=%0b want 1/0", qEof[11], qEol[6]); end
      end
   endtask

   task automatic test_reset_midline();
      clearQ();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) sendCol(8'(10 * c), 8'(10 * c), 8'(10 * c), (c == 0));
      idle(1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL prereset_valid got %0b want 1", out_valid); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || gx !== 11'd0) begin errors++; $display("[TB] FAIL async_reset got vld=%0b gx=%h want 0/000", out_valid, gx); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      clearQ();
      for (int c = 0; c < 3; c++) sendCol(8'(10 * c), 8'(10 * c), 8'(10 * c), 1'b0);
      checks++; if (qGx.size() != 0) begin errors++; $display("[TB] FAIL fresh_early got %0d results want 0", qGx.size()); end
      for (int c = 3; c < 8; c++) sendCol(8'(10 * c), 8'(10 * c), 8'(10 * c), 1'b0);
      idle(3);
      checks++;
      if (qGx.size() != 6) begin errors++; $display("[TB] FAIL fresh_count got %0d want 6", qGx.size()); end
      else begin
         checks++; if (qGx[0] !== 11'd80) begin errors++; $display("[TB] FAIL fresh_first got gx=%h want 050", qGx[0]); end
         checks++; if (qEol[5] !== 1'b1 || qEof[5] !== 1'b0) begin errors++; $display("[TB] FAIL fresh_markers got eol=%0b eof=%0b want 1/0", qEol[5], qEof[5]); end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_vertical_step();
      test_horizontal_step();
      test_back_to_back();
      test_line_boundary();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
